// File: rtl/im_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader
// and the instruction store it feeds.
package im_loader_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 13;

   localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
   localparam int unsigned       DEFAULT_DEPTH     = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; flags the 4th byte of
// each word combinationally so the loader can register the write.
module byte_packer
   import im_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              word_done_c,
   output logic [WORD_W-1:0] word_c
);

   logic [1:0]  cnt;
   logic [23:0] shreg;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         cnt   <= 2'd0;
         shreg <= 24'd0;
      end else if (accept) begin
         cnt   <= cnt + 2'd1;
         shreg <= {shreg[15:0], in_byte};
      end
   end

   assign word_done_c = accept && (cnt == 2'd3);
   assign word_c      = {shreg, in_byte};

endmodule

// File: rtl/im_loader.sv
// Byte-stream program loader: packs bytes into big-endian words and writes
// them to consecutive word addresses from BASE_ADDR.
module im_loader
   import im_loader_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned       DEPTH     = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [IDX_W-1:0]  num_words,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_byte,
   output logic              in_ready,
   output logic              we,
   output logic [WORD_W-1:0] waddr,
   output logic [WORD_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t             state;
   logic [IDX_W-1:0]   count;
   logic [IDX_W-1:0]   idx;
   logic               accept_c;
   logic               start_ok_c;
   logic               word_done_c;
   logic [WORD_W-1:0]  word_c;

   assign accept_c   = in_valid && in_ready;
   assign start_ok_c = start && ((state == ST_IDLE) || (state == ST_DONE));

   byte_packer u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (start_ok_c),
      .accept      (accept_c),
      .in_byte     (in_byte),
      .word_done_c (word_done_c),
      .word_c      (word_c)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         in_ready <= 1'b0;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         count    <= '0;
         idx      <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok_c) begin
                  if (num_words == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b0;
                  end else if (32'(num_words) > DEPTH) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= ST_LOAD;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     done     <= 1'b0;
                     err      <= 1'b0;
                     count    <= num_words;
                     idx      <= '0;
                  end
               end
            end
            ST_LOAD: begin
               if (word_done_c) begin
                  we    <= 1'b1;
                  wdata <= word_c;
                  waddr <= BASE_ADDR + 32'({idx, 2'b00});
                  idx   <= idx + 13'd1;
                  // Last word: leave LOAD on the same edge that takes its final byte.
                  if (idx == 13'(count - 13'd1)) begin
                     state    <= ST_DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: reset, back-to-back words,
// stalls, boundary counts and DONE behaviour.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [12:0] num_words;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   logic        wdone_q[$];

   im_loader dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .num_words (num_words),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .in_ready  (in_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
         wc_q.push_back(cyc);
         wdone_q.push_back(done);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      wdone_q.delete();
   endtask

   task automatic do_start(input logic [12:0] n);
      start     = 1'b1;
      num_words = n;
      tick();
      start     = 1'b0;
   endtask

   // Offer one byte, optionally after a random idle gap; bounded wait for in_ready.
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int gap;
      int guard;
      if (stall) begin
         gap = int'($urandom_range(0, 3));
         in_valid = 1'b0;
         for (int i = 0; i < gap; i++) tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit stall);
      send_byte(w[31:24], stall);
      send_byte(w[23:16], stall);
      send_byte(w[15:8],  stall);
      send_byte(w[7:0],   stall);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_we"},       32'(we),       32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_err"},      32'(err),      32'd0);
      check({tag, "_waddr"},    waddr,         32'h0);
      check({tag, "_wdata"},    wdata,         32'h0);
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      num_words = '0;
      in_valid  = 1'b0;
      in_byte   = '0;

      // Power-on reset
      tick();
      tick();
      check_idle_outputs("por");
      reset_n = 1'b1;
      tick();

      // Reset mid-load
      do_start(13'd2);
      check("ml_busy",     32'(busy),     32'd1);
      check("ml_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_idle_outputs("ml_rst");
      tick();
      check("ml_idle_in_ready", 32'(in_ready), 32'd0);
      clear_log();
      do_start(13'd1);
      send_word(32'h0000_0001, 1'b0);
      check("ml_we",    32'(we),   32'd1);
      check("ml_done",  32'(done), 32'd1);
      tick();
      check("ml_count", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         check("ml_waddr", wa_q[0], 32'h0000_3000);
         check("ml_wdata", wd_q[0], 32'h0000_0001);
      end
      check("ml_we_one_cycle", 32'(we), 32'd0);

      // Back-to-back words
      clear_log();
      do_start(13'd3);
      send_word(32'h2401_0005, 1'b0);
      send_word(32'h2402_0007, 1'b0);
      send_word(32'h0022_1820, 1'b0);
      tick();
      check("bb_count", 32'(wa_q.size()), 32'd3);
      if (wa_q.size() == 3) begin
         check("bb_a0", wa_q[0], 32'h0000_3000);
         check("bb_d0", wd_q[0], 32'h2401_0005);
         check("bb_a1", wa_q[1], 32'h0000_3004);
         check("bb_d1", wd_q[1], 32'h2402_0007);
         check("bb_a2", wa_q[2], 32'h0000_3008);
         check("bb_d2", wd_q[2], 32'h0022_1820);
         check("bb_gap01", 32'(wc_q[1] - wc_q[0]), 32'd4);
         check("bb_gap12", 32'(wc_q[2] - wc_q[1]), 32'd4);
         check("bb_done_p1", 32'(wdone_q[1]), 32'd0);
         check("bb_done_p2", 32'(wdone_q[2]), 32'd1);
      end

      // Stalls
      clear_log();
      do_start(13'd3);
      send_word(32'h2401_0005, 1'b1);
      send_word(32'h2402_0007, 1'b1);
      send_word(32'h0022_1820, 1'b1);
      tick();
      check("st_count", 32'(wa_q.size()), 32'd3);
      if (wa_q.size() == 3) begin
         check("st_a0", wa_q[0], 32'h0000_3000);
         check("st_d0", wd_q[0], 32'h2401_0005);
         check("st_a1", wa_q[1], 32'h0000_3004);
         check("st_d1", wd_q[1], 32'h2402_0007);
         check("st_a2", wa_q[2], 32'h0000_3008);
         check("st_d2", wd_q[2], 32'h0022_1820);
      end
      check("st_done", 32'(done), 32'd1);

      // num_words = 0
      clear_log();
      do_start(13'd0);
      check("z_done", 32'(done), 32'd1);
      check("z_err",  32'(err),  32'd0);
      check("z_busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("z_no_we", 32'(wa_q.size()), 32'd0);

      // num_words = 4097
      do_start(13'd4097);
      check("ov_done", 32'(done), 32'd1);
      check("ov_err",  32'(err),  32'd1);
      check("ov_busy", 32'(busy), 32'd0);
      tick();
      tick();
      check("ov_no_we", 32'(wa_q.size()), 32'd0);

      // num_words = 4096: byte k carries k[7:0]
      do_start(13'd4096);
      check("full_err", 32'(err), 32'd0);
      in_valid = 1'b1;
      for (int k = 0; k < 16384; k++) begin
         in_byte = 8'(k);
         tick();
      end
      in_valid = 1'b0;
      check("full_done", 32'(done), 32'd1);
      tick();
      check("full_count", 32'(wa_q.size()), 32'd4096);
      if (wa_q.size() == 4096) begin
         check("full_first_a", wa_q[0],    32'h0000_3000);
         check("full_first_d", wd_q[0],    32'h0001_0203);
         check("full_last_a",  wa_q[4095], 32'h0000_6FFC);
         check("full_last_d",  wd_q[4095], 32'hFCFD_FEFF);
      end

      // DONE holds off bytes; next start loads from BASE_ADDR
      clear_log();
      in_valid = 1'b1;
      in_byte  = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("dn_in_ready", 32'(in_ready), 32'd0);
         check("dn_done",     32'(done),     32'd1);
      end
      in_valid = 1'b0;
      check("dn_no_we", 32'(wa_q.size()), 32'd0);
      do_start(13'd1);
      send_word(32'hAABB_CCDD, 1'b0);
      tick();
      check("dn_count", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         check("dn_waddr", wa_q[0], 32'h0000_3000);
         check("dn_wdata", wd_q[0], 32'hAABB_CCDD);
      end
      check("dn_done_after", 32'(done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
